// File: rtl/gate_tt_sequencer_if.sv
// Bundle between the self-test sequencer and the board / gate datapath.
// The sequencer attaches through the slave modport.
interface gate_tt_sequencer_if;
  logic        i_start;
  logic        i_auto;
  logic        i_step;
  logic [5:0]  i_y;
  logic        o_a;
  logic        o_b;
  logic [2:0]  o_gate;
  logic        o_led;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [23:0] o_table;

  modport master (
    output i_start, i_auto, i_step, i_y,
    input  o_a, o_b, o_gate, o_led,
    input  o_busy, o_done, o_pass, o_table
  );

  modport slave (
    input  i_start, i_auto, i_step, i_y,
    output o_a, o_b, o_gate, o_led,
    output o_busy, o_done, o_pass, o_table
  );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Truth-table self-test sequencer for the six-gate datapath:
// walks a/b through every combo per gate, captures, compares to golden.
module gate_tt_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int TICK_DIV   = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  gate_tt_sequencer_if.slave bus
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [23:0] GOLDEN = 24'h3617E8;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CAPTURE,
    WAIT_ST,
    DONE
  } state_e;

  state_e       state_q;
  logic [1:0]   combo_q;
  logic [2:0]   gate_q;
  logic [SW-1:0] settle_q;
  logic [TW-1:0] tick_q;
  logic         led_q;
  logic         busy_q;
  logic         done_q;
  logic         pass_q;
  logic [23:0]  table_q;

  logic y_sel;
  logic advance;

  always_comb begin
    y_sel   = bus.i_y[gate_q];
    advance = 1'b0;
    if (state_q == WAIT_ST)
      advance = bus.i_auto ? (tick_q == '0) : bus.i_step;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      combo_q  <= '0;
      gate_q   <= '0;
      settle_q <= '0;
      tick_q   <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      table_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            combo_q <= '0;
            gate_q  <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          settle_q <= SW'(SETTLE_CYC - 1);
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == '0)
            state_q <= CAPTURE;
          else
            settle_q <= settle_q - 1'b1;
        end
        CAPTURE: begin
          table_q[{gate_q, combo_q}] <= y_sel;
          led_q   <= y_sel;
          tick_q  <= TW'(TICK_DIV - 1);
          state_q <= WAIT_ST;
        end
        WAIT_ST: begin
          if (advance) begin
            if (combo_q != 2'd3) begin
              combo_q <= combo_q + 2'd1;
              state_q <= DRIVE;
            end else if (gate_q != 3'd5) begin
              combo_q <= '0;
              gate_q  <= gate_q + 3'd1;
              state_q <= DRIVE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end
          end else if (bus.i_auto) begin
            // manual mode freezes the tick count so a later switch resumes it
            tick_q <= tick_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (table_q == GOLDEN);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_a     = combo_q[1];
  assign bus.o_b     = combo_q[0];
  assign bus.o_gate  = gate_q;
  assign bus.o_led   = led_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_pass  = pass_q;
  assign bus.o_table = table_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: behavioural gate datapath with
// injectable stuck-at faults, expected tables from the golden rules.
module tb_gate_tt_sequencer;

  localparam int S   = 2;
  localparam int T   = 4;
  localparam int RUN = 1 + 24 * (2 + S + T);
  localparam logic [23:0] GOLD = 24'h3617E8;

  logic clk = 1'b0;
  logic reset;
  int   ec = 0;
  int   errors = 0;
  int   checks = 0;

  logic [5:0] stuck_en;
  logic [5:0] stuck_val;

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  gate_tt_sequencer_if bus ();

  gate_tt_sequencer #(
    .SETTLE_CYC(S),
    .TICK_DIV(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always_comb begin
    logic a;
    logic b;
    logic [5:0] y;
    a = bus.o_a;
    b = bus.o_b;
    y = {~a, a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    bus.i_y = (y & ~stuck_en) | (stuck_val & stuck_en);
  end

  function automatic logic [23:0] model_table(input logic [5:0] en,
                                               input logic [5:0] val);
    logic [23:0] t;
    t = '0;
    for (int g = 0; g < 6; g++)
      for (int c = 0; c < 4; c++)
        t[g*4+c] = en[g] ? val[g] : GOLD[g*4+c];
    return t;
  endfunction

  task automatic pulse_start(output int e0);
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    e0 = ec;
    bus.i_start = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk);
    bus.i_step = 1'b1;
    @(negedge clk);
    bus.i_step = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) begin
        ok = 1'b1;
        at = ec;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [32:0] o;
    reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_auto = 1'b1;
    bus.i_step = 1'b0;
    stuck_en = '0;
    stuck_val = '0;
    repeat (3) @(negedge clk);
    o = {bus.o_a, bus.o_b, bus.o_gate, bus.o_led, bus.o_busy,
         bus.o_done, bus.o_pass, bus.o_table};
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    reset = 1'b0;
    bus.i_auto = 1'b0;
    pulse_step();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_table !== '0) begin
      errors++;
      $display("FAIL idle_step: busy=%b table=%h want 0/0",
               bus.o_busy, bus.o_table);
    end
  endtask

  task automatic test_golden();
    int e0, at;
    bit ok;
    stuck_en = '0;
    bus.i_auto = 1'b1;
    pulse_start(e0);
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL golden_busy: got %b want 1", bus.o_busy);
    end
    wait_done(RUN + 20, ok, at);
    checks++;
    if (!ok || at - e0 != RUN) begin
      errors++;
      $display("FAIL golden_latency: ok=%0d got %0d want %0d",
               ok, at - e0, RUN);
    end
    checks++;
    if (bus.o_table !== GOLD || bus.o_pass !== 1'b1) begin
      errors++;
      $display("FAIL golden_table: got %h/%b want %h/1",
               bus.o_table, bus.o_pass, GOLD);
    end
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL golden_after: busy=%b done=%b want 0/0",
               bus.o_busy, bus.o_done);
    end
  endtask

  task automatic test_fault();
    int e0, at;
    bit ok;
    logic [23:0] exp_t;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        stuck_en = 6'b010000;
        stuck_val = 6'b000000;
      end else begin
        stuck_en = 6'($urandom_range(1, 63));
        stuck_val = 6'($urandom);
      end
      exp_t = model_table(stuck_en, stuck_val);
      bus.i_auto = 1'b1;
      pulse_start(e0);
      wait_done(RUN + 20, ok, at);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL fault_done[%0d]: no done within %0d", it, RUN + 20);
      end
      checks++;
      if (bus.o_table !== exp_t) begin
        errors++;
        $display("FAIL fault_table[%0d]: got %h want %h",
                 it, bus.o_table, exp_t);
      end
      checks++;
      if (bus.o_pass !== (exp_t == GOLD)) begin
        errors++;
        $display("FAIL fault_pass[%0d]: got %b want %b",
                 it, bus.o_pass, exp_t == GOLD);
      end
    end
    stuck_en = '0;
  endtask

  task automatic test_manual();
    int e0, at;
    bit ok;
    logic [23:0] exp_t;
    logic [7:0] got, want;
    stuck_en = 6'b000100;
    stuck_val = 6'b000100;
    exp_t = model_table(stuck_en, stuck_val);
    bus.i_auto = 1'b0;
    pulse_start(e0);
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(7, 12)) @(negedge clk);
      got = {bus.o_gate, bus.o_a, bus.o_b, bus.o_led, bus.o_busy, 1'b0};
      want = {3'(k / 4), 2'(k % 4), exp_t[k], 1'b1, 1'b0};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL manual_step[%0d]: got %b want %b", k, got, want);
      end
      pulse_step();
    end
    wait_done(10, ok, at);
    checks++;
    if (!ok || bus.o_table !== exp_t || bus.o_pass !== 1'b0) begin
      errors++;
      $display("FAIL manual_done: ok=%0d table=%h pass=%b want %h/0",
               ok, bus.o_table, bus.o_pass, exp_t);
    end
    repeat (3) pulse_step();
    repeat (2) @(negedge clk);
    got = {bus.o_gate, bus.o_a, bus.o_b, bus.o_busy, 2'b00};
    checks++;
    if (got !== 8'b101_1_1_0_00 || bus.o_table !== exp_t) begin
      errors++;
      $display("FAIL manual_idle_steps: got %b/%h want 10111000/%h",
               got, bus.o_table, exp_t);
    end
    stuck_en = '0;
  endtask

  task automatic test_restart();
    int e0, e1, at;
    bit ok;
    bus.i_auto = 1'b1;
    pulse_start(e0);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      bus.i_step = 1'($urandom);
    end
    bus.i_step = 1'b0;
    pulse_start(e1);
    wait_done(RUN + 20, ok, at);
    checks++;
    if (!ok || at - e0 != RUN) begin
      errors++;
      $display("FAIL restart_latency: ok=%0d got %0d want %0d",
               ok, at - e0, RUN);
    end
    checks++;
    if (bus.o_table !== GOLD || bus.o_pass !== 1'b1) begin
      errors++;
      $display("FAIL restart_table: got %h/%b want %h/1",
               bus.o_table, bus.o_pass, GOLD);
    end
  endtask

  task automatic test_reset_midrun();
    int e0, at;
    bit ok;
    bit hit;
    logic [32:0] o;
    bus.i_auto = 1'b1;
    pulse_start(e0);
    hit = 1'b0;
    for (int i = 0; i < RUN; i++) begin
      @(negedge clk);
      if (bus.o_gate == 3'd3 && {bus.o_a, bus.o_b} == 2'b10) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midrun_reach: got no gate3/combo2 want reached");
    end
    #2 reset = 1'b1;
    #1;
    o = {bus.o_a, bus.o_b, bus.o_gate, bus.o_led, bus.o_busy,
         bus.o_done, bus.o_pass, bus.o_table};
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL midrun_async: got %h want 0", o);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: busy got %b want 0", bus.o_busy);
    end
    pulse_start(e0);
    wait_done(RUN + 20, ok, at);
    checks++;
    if (!ok || at - e0 != RUN || bus.o_pass !== 1'b1 ||
        bus.o_table !== GOLD) begin
      errors++;
      $display("FAIL midrun_rerun: ok=%0d lat=%0d pass=%b table=%h want 1/%0d/1/%h",
               ok, at - e0, bus.o_pass, bus.o_table, RUN, GOLD);
    end
  endtask

  task automatic test_mode_switch();
    int e0, s, at, ksw, want_lat;
    bit ok;
    ksw = $urandom_range(8, 11);
    bus.i_auto = 1'b0;
    pulse_start(e0);
    for (int k = 0; k < ksw; k++) begin
      repeat (10) @(negedge clk);
      pulse_step();
    end
    repeat (10) @(negedge clk);
    bus.i_auto = 1'b1;
    s = ec;
    // held tick count drains, then each remaining step takes a full slot
    want_lat = T + (23 - ksw) * (2 + S + T) + 1;
    wait_done(want_lat + 20, ok, at);
    checks++;
    if (!ok || at - s != want_lat) begin
      errors++;
      $display("FAIL mode_latency: ok=%0d got %0d want %0d",
               ok, at - s, want_lat);
    end
    checks++;
    if (bus.o_table !== GOLD || bus.o_pass !== 1'b1) begin
      errors++;
      $display("FAIL mode_table: got %h/%b want %h/1",
               bus.o_table, bus.o_pass, GOLD);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_fault();
    test_manual();
    test_restart();
    test_reset_midrun();
    test_mode_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
